// File: rtl/mem_responder.sv
// mem_responder: single-outstanding word memory responder with WAIT_CYCLES busy cycles per request.
// Define MEM_RESPONDER_ADDR_CHECK_EN to flag misaligned or out-of-range addresses via resp_err.
module mem_responder #(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam logic [3:0] WAIT = 4'(WAIT_CYCLES);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic we_q, we_d, err_q, err_d, resp_err_q;
  logic [ADDR_W-1:0] idx_q, idx_d, cur_idx;
  logic [31:0] wdata_q, wdata_d, rdata_q, cur_wdata;
  logic req_err, accept, to_resp, cur_we, cur_err;
  logic [31:0] mem [DEPTH];
`ifdef MEM_RESPONDER_ADDR_CHECK_EN
  assign req_err = (|req_addr[1:0]) || (|req_addr[31:ADDR_W+2]);
`else
  logic addr_unused;
  assign addr_unused = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};
  assign req_err = 1'b0;
`endif
  assign req_ready  = rst_n && state_q == IDLE;
  assign resp_valid = rst_n && state_q == RESP;
  assign resp_rdata = rdata_q;
  assign resp_err   = resp_err_q;
  assign accept     = req_ready && req_valid;
  // With zero wait states the access happens on the accept edge, so use the live request.
  assign to_resp   = (accept && WAIT == 4'd0) || (state_q == BUSY && cnt_q == 4'd1);
  assign cur_we    = accept ? req_we : we_q;
  assign cur_err   = accept ? req_err : err_q;
  assign cur_idx   = accept ? req_addr[ADDR_W+1:2] : idx_q;
  assign cur_wdata = accept ? req_wdata : wdata_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        idx_d   = req_addr[ADDR_W+1:2];
        wdata_d = req_wdata;
        err_d   = req_err;
        cnt_d   = WAIT;
        state_d = WAIT == 4'd0 ? RESP : BUSY;
      end
      BUSY: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = cnt_q == 4'd1 ? RESP : BUSY;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      if (to_resp) begin
        resp_err_q <= cur_err;
        if (cur_err) rdata_q <= '0;
        else if (!cur_we) rdata_q <= mem[cur_idx];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n && to_resp && cur_we && !cur_err) mem[cur_idx] <= cur_wdata;
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: four responders (WAIT_CYCLES 1,0,3,2) driven from a vector table with a response scoreboard.
module tb_mem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] vld, rdy, we, rv, err;
  logic [31:0] addr [4];
  logic [31:0] wd [4];
  logic [31:0] rd [4];
  int n_chk = 0, n_fail = 0, cyc = 0;
  typedef struct {int k; bit chk; logic [31:0] rd; bit err;} exp_t;
  typedef struct {int k; bit w; logic [31:0] a; logic [31:0] d; logic [31:0] rd; bit err;} vec_t;
  exp_t sb[$];
  exp_t e;
  vec_t v[$];
  int acc_t[$];
`ifdef MEM_RESPONDER_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  always #5 clk = ~clk;
  for (genvar i = 0; i < 4; i++) begin : g_dut
    mem_responder #(.WAIT_CYCLES(i == 0 ? 1 : i == 1 ? 0 : i == 2 ? 3 : 2)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(vld[i]), .req_ready(rdy[i]), .req_we(we[i]),
      .req_addr(addr[i]), .req_wdata(wd[i]), .resp_valid(rv[i]), .resp_rdata(rd[i]), .resp_err(err[i])
    );
  end
  function automatic int wc(int k);
    return k == 0 ? 1 : k == 1 ? 0 : k == 2 ? 3 : 2;
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (vld[2] && rdy[2]) acc_t.push_back(cyc);
  end
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) if (rv[k] === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_resp: inst %0d got resp_valid want none", k);
      end else begin
        e = sb.pop_front();
        check("resp_inst", k, e.k);
        check("resp_err", {31'd0, err[k]}, {31'd0, e.err});
        if (e.chk) check("resp_rdata", rd[k], e.rd);
      end
    end
  end
  task automatic xact(int k, bit w, logic [31:0] a, logic [31:0] d, logic [31:0] exp_rd, bit exp_err);
    int t = 0, lat = 0;
    bit rdy_ok = 1'b1;
    vld[k] = 1'b1; we[k] = w; addr[k] = a; wd[k] = d;
    while (!rdy[k] && t < 20) begin @(negedge clk); t++; end
    check("accept", {31'd0, rdy[k]}, 32'd1);
    if (!rdy[k]) begin vld[k] = 1'b0; return; end
    @(posedge clk);
    sb.push_back('{k, !w || exp_err, exp_rd, exp_err});
    #1 vld[k] = 1'b0; we[k] = 1'($urandom); addr[k] = $urandom; wd[k] = $urandom;
    do begin
      @(negedge clk);
      lat++;
      if (rdy[k]) rdy_ok = 1'b0;
    end while (!rv[k] && lat < 20);
    check("latency", lat, wc(k) + 1);
    check("ready_low", {31'd0, rdy_ok}, 32'd1);
    @(negedge clk);
    check("pulse_end", {31'd0, rv[k]}, 32'd0);
    check("ready_again", {31'd0, rdy[k]}, 32'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int t;
    vld = '0; we = '0;
    for (int k = 0; k < 4; k++) begin addr[k] = '0; wd[k] = '0; end
    v.push_back('{0, 1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0});
    v.push_back('{0, 0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0});
    v.push_back('{0, 1, 32'h14, 32'hA5A5A5A5, 32'h0, 1'b0});
    v.push_back('{0, 0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0});
    v.push_back('{0, 0, 32'h14, 32'h0, 32'hA5A5A5A5, 1'b0});
    v.push_back('{0, 1, 32'h0, 32'h11111111, 32'h0, 1'b0});
    v.push_back('{0, 0, 32'h400, 32'h0, CHK ? 32'h0 : 32'h11111111, CHK});
    v.push_back('{0, 1, 32'h20, 32'h55555555, 32'h0, 1'b0});
    v.push_back('{0, 1, 32'h22, 32'hCAFEF00D, 32'h0, CHK});
    v.push_back('{0, 0, 32'h20, 32'h0, CHK ? 32'h55555555 : 32'hCAFEF00D, 1'b0});
    v.push_back('{0, 0, 32'h410, 32'h0, CHK ? 32'h0 : 32'hDEADBEEF, CHK});
    v.push_back('{1, 1, 32'h0, 32'h00000004, 32'h0, 1'b0});
    v.push_back('{1, 0, 32'h0, 32'h0, 32'h00000004, 1'b0});
    v.push_back('{1, 1, 32'h4, 32'h89ABCDEF, 32'h0, 1'b0});
    v.push_back('{1, 0, 32'h0, 32'h0, 32'h00000004, 1'b0});
    v.push_back('{1, 0, 32'h4, 32'h0, 32'h89ABCDEF, 1'b0});
    v.push_back('{1, 1, 32'h0, 32'h0BADF00D, 32'h0, 1'b0});
    v.push_back('{1, 0, 32'h0, 32'h0, 32'h0BADF00D, 1'b0});
    v.push_back('{2, 1, 32'h30, 32'h33333333, 32'h0, 1'b0});
    v.push_back('{2, 1, 32'h34, 32'h34343434, 32'h0, 1'b0});
    v.push_back('{3, 1, 32'h20, 32'hAAAA0000, 32'h0, 1'b0});
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) check("rst_ready", {31'd0, rdy[k]}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("idle_ready", {31'd0, rdy[k]}, 32'd1);
      check("idle_valid", {31'd0, rv[k]}, 32'd0);
      check("idle_rdata", rd[k], 32'd0);
      check("idle_err", {31'd0, err[k]}, 32'd0);
    end
    foreach (v[i]) xact(v[i].k, v[i].w, v[i].a, v[i].d, v[i].rd, v[i].err);
    // held request during BUSY: address change must not affect the in-flight read
    acc_t.delete();
    vld[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h30;
    @(posedge clk);
    sb.push_back('{2, 1'b1, 32'h33333333, 1'b0});
    #1 addr[2] = 32'h34;
    t = 0;
    while (acc_t.size() < 2 && t < 20) begin @(negedge clk); t++; end
    vld[2] = 1'b0;
    sb.push_back('{2, 1'b1, 32'h34343434, 1'b0});
    check("busy_accepts", acc_t.size(), 2);
    if (acc_t.size() == 2) check("accept_gap", acc_t[1] - acc_t[0], 5);
    repeat (6) @(negedge clk);
    check("busy_sb_empty", sb.size(), 0);
    // reset during BUSY aborts the pending write
    vld[3] = 1'b1; we[3] = 1'b1; addr[3] = 32'h20; wd[3] = 32'h12345678;
    @(posedge clk);
    #1 vld[3] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("midrst_valid", {31'd0, rv[3]}, 32'd0);
      check("midrst_ready", {31'd0, rdy[3]}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid", {31'd0, rv[3]}, 32'd0);
    check("post_rst_ready", {31'd0, rdy[3]}, 32'd1);
    check("post_rst_rdata0", rd[0], 32'd0);
    check("post_rst_rdata2", rd[2], 32'd0);
    xact(3, 1'b0, 32'h20, 32'h0, 32'hAAAA0000, 1'b0);
    xact(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    repeat (3) @(negedge clk);
    check("final_sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle CPU's instruction/data memory port. It serves one outstanding word read or write at a time over a valid/ready request and response handshake.
- Backed by an internal synchronous word array with a configurable wait-state count.
- Replaces the raw dual-port RAM so that memory latency can vary and the CPU control FSM can be tested against stalls.

Parameters:
- DEPTH, 256, number of 32-bit words in the array; must be a power of two.
- ADDR_W, 8, word-index width; equals log2(DEPTH).
- WAIT_CYCLES, 1, extra busy cycles between request accept and response; legal range 0..15.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  1  request present; initiator holds it and all req_* fields stable until accepted.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  32  byte address; word index = req_addr[ADDR_W+1:2].
- req_wdata  input  32  write data.
- resp_valid  output  1  one-cycle pulse: request completed.
- resp_rdata  output  32  read data; valid when resp_valid && the request was a read.
- resp_err  output  1  error flag qualified by resp_valid (see Optional Feature).

Behaviour:
- Reset:
  - Sampled on clk edge when rst_n=0.
  - state=IDLE, req_ready=0 during the reset cycle and 1 in the first cycle after release.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - Wait counter = 0; captured request registers = 0.
  - Array contents are NOT reset.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1: capture we, word index, wdata and error status.
  - Load the counter with WAIT_CYCLES.
  - Go to BUSY if WAIT_CYCLES>0, else go directly to RESP.
- BUSY:
  - req_ready=0. The counter decrements each cycle.
  - When counter==1 at the edge, go to RESP.
  - BUSY therefore lasts exactly WAIT_CYCLES cycles.
- Transition into RESP (same edge):
  - Write: if we=1 and no error, mem[idx] <= wdata; resp_rdata is unchanged.
  - Read: if we=0 and no error, resp_rdata <= mem[idx].
  - Error: resp_rdata <= 0.
- RESP:
  - resp_valid=1 and req_ready=0 for exactly one cycle.
  - No response back-pressure; the initiator must sample in that cycle.
  - Next state is IDLE.
- Latency:
  - Request accepted at edge N gives resp_valid high in cycle N+1+WAIT_CYCLES.
  - The next accept is possible at edge N+2+WAIT_CYCLES.
- resp_rdata and resp_err hold their values after RESP until the next response.
- Read-after-write to the same address in back-to-back requests returns the newly written data.
- req_valid while req_ready=0 is ignored and not queued. The initiator must keep it asserted.
- Changing req_* inputs after acceptance has no effect on the transaction in flight.
- Reset mid-operation (BUSY or RESP): the transaction is aborted, a pending write is NOT performed, no resp_valid is produced, and all outputs take their reset values.
- The address wraps modulo DEPTH on the upper bits unless the optional check is enabled.

Optional Feature:
- Macro: MEM_RESPONDER_ADDR_CHECK_EN.
- Defined:
  - A request is errored if req_addr[1:0]!=0 or req_addr[31:ADDR_W+2]!=0.
  - An errored request still completes with normal latency, with resp_err=1 on the response.
  - Any write is suppressed and resp_rdata=0.
- Undefined:
  - addr[1:0] and the upper bits are ignored, so the address wraps.
  - resp_err is tied to 0.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, then release. Required: req_ready=1 one cycle after release; resp_valid=0, resp_rdata=0.
- Write/read, WAIT_CYCLES=1:
  - Write 0xDEADBEEF to addr 0x10, accepted at edge N. Required: resp_valid in cycle N+2.
  - Then read 0x10. Required: resp_rdata=0xDEADBEEF and resp_err=0 with resp_valid.
- Zero wait, WAIT_CYCLES=0:
  - Read addr 0x0 after writing 0x00000004. Required: resp_valid in the cycle after accept; req_ready low for exactly 1 cycle per transaction.
  - Back-to-back reads of 0x0 and 0x4 succeed.
- Busy ignore, WAIT_CYCLES=3:
  - Hold req_valid asserted continuously with a new address during BUSY. Required: exactly one accept per 5 cycles; the in-flight address is unaffected.
- Reset mid-write, WAIT_CYCLES=2:
  - Write 0x12345678 to addr 0x20, then assert rst_n=0 during BUSY. Required: no resp_valid.
  - A subsequent read of 0x20 returns the prior contents, not 0x12345678.
- Addr check (macro defined):
  - Write to 0x22 (misaligned). Required: resp_err=1, and mem at 0x20 is unchanged.
  - Read 0x400 with DEPTH=256. Required: resp_err=1, resp_rdata=0.
  - Without the macro, the read of 0x400 returns mem[0] and resp_err=0.
